// File: rtl/piso_tx_pkg.sv
// Shared definitions for the piso_tx parallel-in/serial-out transmitter.
// FSM state encoding shared by the transmitter and anything that observes its state.
package piso_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

endpackage

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word over valid/ready and shifts it out MSB
// first, one bit per i_ce edge. Optional even parity bit with `define PISO_TX_PARITY_EN.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_ce,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_data,
    output logic             o_active,
    output logic             o_done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               data_q, data_d;
    logic               active_q, active_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
`ifdef PISO_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        active_d = active_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
`ifdef PISO_TX_PARITY_EN
        parity_d = parity_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // Acceptance is not qualified by i_ce; the first bit appears immediately.
                if (i_valid && ready_q) begin
                    state_d  = ST_SHIFT;
                    data_d   = i_data[WIDTH-1];
                    shreg_d  = {i_data[WIDTH-2:0], 1'b0};
                    cnt_d    = CNT_LAST;
                    active_d = 1'b1;
                    ready_d  = 1'b0;
`ifdef PISO_TX_PARITY_EN
                    parity_d = ^i_data;
`endif
                end
            end

            ST_SHIFT: begin
                if (i_ce) begin
                    if (cnt_q != '0) begin
                        data_d  = shreg_q[WIDTH-1];
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        cnt_d   = cnt_q - 1'b1;
                    end else begin
`ifdef PISO_TX_PARITY_EN
                        state_d = ST_PARITY;
                        data_d  = parity_q;
`else
                        state_d  = ST_IDLE;
                        data_d   = 1'b0;
                        active_d = 1'b0;
                        ready_d  = 1'b1;
                        done_d   = 1'b1;
`endif
                    end
                end
            end

`ifdef PISO_TX_PARITY_EN
            ST_PARITY: begin
                if (i_ce) begin
                    state_d  = ST_IDLE;
                    data_d   = 1'b0;
                    active_d = 1'b0;
                    ready_d  = 1'b1;
                    done_d   = 1'b1;
                end
            end
`endif

            default: begin
                // Unreachable encoding: fall back to the reset condition.
                state_d  = ST_IDLE;
                shreg_d  = '0;
                cnt_d    = '0;
                data_d   = 1'b0;
                active_d = 1'b0;
                ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            data_q   <= 1'b0;
            active_q <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            active_q <= active_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
`ifdef PISO_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign o_ready  = ready_q;
    assign o_data   = data_q;
    assign o_active = active_q;
    assign o_done   = done_q;

`ifdef FORMAL
    a_done_not_active: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !(o_done && o_active));
    a_ready_not_active: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !(o_ready && o_active));
    a_ready_is_idle: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        o_ready == (state_q == ST_IDLE));
    a_done_one_cycle: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        o_done |=> !o_done);
    a_cnt_in_range: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        cnt_q <= CNT_LAST);
    a_idle_data_low: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !o_active |-> !o_data);
`endif

endmodule
